// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC select with RUN/HALT/ISR control and saved return PC.
// Interrupt support (irq, reti, epc) is built only when PC_SEQ_IRQ_EN is defined.
module pc_sequencer #(
  parameter int              WIDTH      = 16,
  parameter logic [WIDTH-1:0] RESET_PC   = '0,
  parameter logic [WIDTH-1:0] IRQ_VECTOR = 'h10,
  parameter int              PC_INC     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] current_pc,
  input  logic             stall,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             halt,
  input  logic             resume,
  input  logic             irq,
  input  logic             reti,
  output logic [WIDTH-1:0] new_pc,
  output logic             irq_ack,
  output logic [WIDTH-1:0] epc,
  output logic [1:0]       state
);
  localparam logic [1:0] RUN = 2'd0, HALT = 2'd1, ISR = 2'd2;
  logic [1:0] state_q, state_d;
  logic [WIDTH-1:0] seq, fall;
  logic take_irq, take_reti, legal;
  assign seq  = current_pc + WIDTH'(PC_INC);
  assign fall = jump ? jump_target : branch_taken ? branch_target : seq;
`ifdef PC_SEQ_IRQ_EN
  logic [WIDTH-1:0] epc_q, epc_d;
  assign legal     = state_q != 2'd3;
  // a concurrent jump/branch becomes the return address so it is never lost
  assign take_irq  = !rst && irq && !stall && (state_q == HALT || (state_q == RUN && !halt));
  assign take_reti = state_q == ISR && reti && !halt && !stall;
  always_comb epc_d = !take_irq ? epc_q : state_q == HALT ? current_pc : fall;
  always_ff @(posedge clk) begin
    if (rst) epc_q <= '0;
    else epc_q <= epc_d;
  end
  assign epc = epc_q;
`else
  logic unused_irq;
  assign unused_irq = irq ^ reti;
  assign legal      = state_q == RUN || state_q == HALT;
  assign take_irq   = 1'b0;
  assign take_reti  = 1'b0;
  assign epc        = '0;
`endif
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = take_irq ? ISR :
              !legal ? RUN :
              state_q == HALT ? ((resume && !halt) ? RUN : HALT) :
              halt ? HALT :
              take_reti ? RUN : state_q;
  end
  // the PC register has no enable, so every hold feeds current_pc back
  always_comb begin
    new_pc  = rst ? RESET_PC :
              take_irq ? IRQ_VECTOR :
              (!legal || state_q == HALT || halt || stall) ? current_pc :
              take_reti ? epc : fall;
    irq_ack = take_irq;
  end
  assign state = state_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed plan scenarios plus randomized traffic against a rule-level model.
module tb_pc_sequencer;
`ifdef PC_SEQ_IRQ_EN
  localparam bit IEN = 1'b1;
`else
  localparam bit IEN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, stall, jump, branch_taken, halt, resume, irq, reti;
  logic [15:0] current_pc, jump_target, branch_target;
  logic [15:0] new_pc, epc;
  logic irq_ack;
  logic [1:0] state;
  int n_chk = 0, n_err = 0;
  int m_state = 0;
  logic [15:0] m_epc = 16'h0;
  logic [15:0] s_pc, s_epc;
  logic s_ack;
  logic [1:0] s_state;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .current_pc(current_pc), .stall(stall), .jump(jump),
    .jump_target(jump_target), .branch_taken(branch_taken), .branch_target(branch_target),
    .halt(halt), .resume(resume), .irq(irq), .reti(reti),
    .new_pc(new_pc), .irq_ack(irq_ack), .epc(epc), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Spec-level rules: priority list per mode, 0=RUN 1=HALT 2=ISR
  task automatic model(output logic [15:0] pc, output logic ack, output int ns, output logic [15:0] ne);
    logic [15:0] sq, ft;
    sq = current_pc + 16'd1;
    ft = jump ? jump_target : branch_taken ? branch_target : sq;
    pc = current_pc; ack = 1'b0; ns = m_state; ne = m_epc;
    if (rst) begin
      pc = 16'h0; ns = 0; ne = 16'h0;
      return;
    end
    case (m_state)
      0: if (halt) ns = 1;
         else if (stall) ns = 0;
         else if (IEN && irq) begin pc = 16'h0010; ack = 1'b1; ne = ft; ns = 2; end
         else pc = ft;
      1: if (IEN && irq && !stall) begin pc = 16'h0010; ack = 1'b1; ne = current_pc; ns = 2; end
         else if (resume && !halt) ns = 0;
      default: if (halt) ns = 1;
         else if (stall) ns = 2;
         else if (reti) begin pc = m_epc; ns = 0; end
         else pc = ft;
    endcase
  endtask

  task automatic cyc();
    logic [15:0] e_pc, e_epc;
    logic e_ack;
    int e_ns;
    @(negedge clk);
    model(e_pc, e_ack, e_ns, e_epc);
    s_pc = new_pc; s_ack = irq_ack; s_state = state; s_epc = epc;
    chk("new_pc", {16'h0, new_pc}, {16'h0, e_pc});
    chk("irq_ack", {31'h0, irq_ack}, {31'h0, e_ack});
    chk("state", {30'h0, state}, 32'(m_state));
    chk("epc", {16'h0, epc}, {16'h0, m_epc});
    m_state = e_ns;
    m_epc = e_epc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; stall = 0; jump = 0; branch_taken = 0; halt = 0; resume = 0; irq = 0; reti = 0;
    jump_target = 16'h0; branch_target = 16'h0;
  endtask

  initial begin
    idle();
    rst = 1; current_pc = 16'h0;
    @(posedge clk); #1;
    cyc(); chk("rst_pc0", {16'h0, s_pc}, 32'h0);
    cyc(); chk("rst_pc1", {16'h0, s_pc}, 32'h0);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      current_pc = 16'(i);
      cyc(); chk("seq_pc", {16'h0, s_pc}, 32'(i + 1));
    end
    chk("seq_state", {30'h0, s_state}, 32'h0);
    chk("seq_epc", {16'h0, s_epc}, 32'h0);

    current_pc = 16'h0040; stall = 1; jump = 1; jump_target = 16'h0100;
    cyc(); chk("stall_hold", {16'h0, s_pc}, 32'h0040);
    stall = 0;
    cyc(); chk("stall_jump", {16'h0, s_pc}, 32'h0100);
    idle();

`ifdef PC_SEQ_IRQ_EN
    current_pc = 16'h0020; irq = 1; branch_taken = 1; branch_target = 16'h0080;
    cyc(); chk("irq_pc", {16'h0, s_pc}, 32'h0010); chk("irq_ack", {31'h0, s_ack}, 32'h1);
    current_pc = 16'h0010; branch_taken = 0;
    cyc(); chk("isr_epc", {16'h0, s_epc}, 32'h0080); chk("isr_state", {30'h0, s_state}, 32'h2);
    chk("isr_noack", {31'h0, s_ack}, 32'h0); chk("isr_seq", {16'h0, s_pc}, 32'h0011);
    irq = 0; reti = 1; current_pc = 16'h0011;
    cyc(); chk("reti_pc", {16'h0, s_pc}, 32'h0080);
    reti = 0; current_pc = 16'h0080;
    cyc(); chk("reti_state", {30'h0, s_state}, 32'h0);
`else
    current_pc = 16'h0020; irq = 1;
    cyc(); chk("noirq_pc", {16'h0, s_pc}, 32'h0021); chk("noirq_ack", {31'h0, s_ack}, 32'h0);
    irq = 0;
`endif

    current_pc = 16'hFFFF;
    cyc(); chk("wrap", {16'h0, s_pc}, 32'h0);

    current_pc = 16'h0033; halt = 1;
    cyc(); chk("halt_pc", {16'h0, s_pc}, 32'h0033);
    halt = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(); chk("halt_hold", {16'h0, s_pc}, 32'h0033); chk("halt_state", {30'h0, s_state}, 32'h1);
    end
    resume = 1;
    cyc();
    resume = 0;
    cyc(); chk("resume_state", {30'h0, s_state}, 32'h0); chk("resume_pc", {16'h0, s_pc}, 32'h0034);

    halt = 1;
    cyc();
    halt = 0;
`ifdef PC_SEQ_IRQ_EN
    irq = 1;
    cyc(); chk("wake_pc", {16'h0, s_pc}, 32'h0010); chk("wake_ack", {31'h0, s_ack}, 32'h1);
    irq = 0; current_pc = 16'h0010;
    cyc(); chk("wake_epc", {16'h0, s_epc}, 32'h0033); chk("wake_state", {30'h0, s_state}, 32'h2);
`endif
    rst = 1;
    cyc(); chk("midrst_pc", {16'h0, s_pc}, 32'h0);
    rst = 0;
    cyc(); chk("midrst_state", {30'h0, s_state}, 32'h0); chk("midrst_epc", {16'h0, s_epc}, 32'h0);

    for (int i = 0; i < 2000; i++) begin
      rst = $urandom_range(0, 99) < 2;
      stall = $urandom_range(0, 99) < 15;
      halt = $urandom_range(0, 99) < 5;
      resume = $urandom_range(0, 99) < 20;
      irq = $urandom_range(0, 99) < 15;
      reti = $urandom_range(0, 99) < 15;
      jump = $urandom_range(0, 99) < 20;
      branch_taken = $urandom_range(0, 99) < 20;
      jump_target = 16'($urandom);
      branch_target = 16'($urandom);
      case ($urandom_range(0, 9))
        0: current_pc = 16'hFFFF;
        1, 2, 3: current_pc = 16'($urandom);
        default: current_pc = s_pc;
      endcase
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
